// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state encoding, R/W and ACK
// bit constants, and the datapath widths.
package i2c_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_CNT_W = 4;

  localparam logic [BIT_CNT_W-1:0] BITS_PER_BYTE = BIT_CNT_W'(8);

  // Direction bit carried in the LSB of the address byte
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  // SDA level on the 9th clock of a byte
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes the asynchronous SCL/SDA bus levels into clk_i and detects
// SCL edges plus START/STOP conditions on the synchronized values.
//
// Ports:
//   clk_i, rst_i      system clock, synchronous active-high reset
//   scl_i, sda_i      raw bus levels
//   sda_o             synchronized SDA level (flop output)
//   scl_rise_c_o      synchronized SCL rose this cycle
//   scl_fall_c_o      synchronized SCL fell this cycle
//   start_c_o         SDA fell while SCL held high
//   stop_c_o          SDA rose while SCL held high
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_c_o,
  output logic scl_fall_c_o,
  output logic start_c_o,
  output logic stop_c_o
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_prev;
  logic                   r_sda_prev;
  logic                   w_scl;
  logic                   w_sda;

  // Synchronizer chains plus one history flop per line; idle bus is high
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
    end
  end

  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];
  assign sda_o = w_sda;

  assign scl_rise_c_o = w_scl & ~r_scl_prev;
  assign scl_fall_c_o = ~w_scl & r_scl_prev;

  // SCL must be high on both samples so an SCL edge is never read as START/STOP
  assign start_c_o = r_sda_prev & ~w_sda & w_scl & r_scl_prev;
  assign stop_c_o  = ~r_sda_prev & w_sda & w_scl & r_scl_prev;

endmodule

// File: rtl/i2c_target.sv
// I2C target with an 8-bit register pointer. A write sets the pointer and
// then writes successive registers; a read streams successive registers.
// The pointer auto-increments (wrapping 0xFF -> 0x00) after each byte.
//
// Ports:
//   clk_i, rst_i   system clock, synchronous active-high reset
//   scl_i, sda_i   raw bus levels
//   sda_oe_o       1 = pull SDA low
//   reg_addr_o     register pointer
//   reg_wdata_o    write data, valid with reg_we_o
//   reg_we_o       one-cycle write strobe
//   reg_re_o       one-cycle read strobe, reg_rdata_i valid the cycle after
//   reg_rdata_i    read data from the register file
//   busy_o         addressed transaction in progress
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  ADDRESS     = 7'h40,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe_o,
  output logic [7:0]  reg_addr_o,
  output logic [7:0]  reg_wdata_o,
  output logic        reg_we_o,
  output logic        reg_re_o,
  input  logic [7:0]  reg_rdata_i,
  output logic        busy_o
);

  logic                 w_sda;
  logic                 w_scl_rise;
  logic                 w_scl_fall;
  logic                 w_start;
  logic                 w_stop;

  state_t               r_state;
  logic [BYTE_W-1:0]    r_shift;
  logic [BYTE_W-1:0]    r_tx;
  logic [BIT_CNT_W-1:0] r_bitcnt;
  logic [BYTE_W-1:0]    r_ptr;
  logic [BYTE_W-1:0]    r_wdata;
  logic                 r_rw;
  logic                 r_ack;
  logic                 r_load;
  logic                 r_oe;
  logic                 r_we;
  logic                 r_re;
  logic                 r_busy;

  i2c_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .scl_i        (scl_i),
    .sda_i        (sda_i),
    .sda_o        (w_sda),
    .scl_rise_c_o (w_scl_rise),
    .scl_fall_c_o (w_scl_fall),
    .start_c_o    (w_start),
    .stop_c_o     (w_stop)
  );

  // Protocol FSM with registered bus and register-file outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_shift  <= '0;
      r_tx     <= '0;
      r_bitcnt <= '0;
      r_ptr    <= '0;
      r_wdata  <= '0;
      r_rw     <= RW_WRITE;
      r_ack    <= NACK;
      r_load   <= 1'b0;
      r_oe     <= 1'b0;
      r_we     <= 1'b0;
      r_re     <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_we <= 1'b0;
      r_re <= 1'b0;

      // Pointer advances the cycle after a write so the strobe sees the old value
      if (r_we) begin
        r_ptr <= r_ptr + 8'd1;
      end

      // Read pipeline: strobe cycle, then data valid cycle where the byte is loaded
      if (r_re) begin
        r_load <= 1'b1;
      end
      if (r_load) begin
        r_load <= 1'b0;
        if (r_state == ST_RDATA) begin
          r_tx <= reg_rdata_i;
          r_oe <= ~reg_rdata_i[7];
        end
      end

      if (w_start) begin
        // Repeated START keeps the pointer and busy until the address resolves
        r_state  <= ST_ADDR;
        r_bitcnt <= '0;
        r_oe     <= 1'b0;
        r_load   <= 1'b0;
      end else if (w_stop) begin
        r_state  <= ST_IDLE;
        r_bitcnt <= '0;
        r_oe     <= 1'b0;
        r_load   <= 1'b0;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          ST_ADDR, ST_REG, ST_WDATA: begin
            if (w_scl_rise) begin
              r_shift  <= {r_shift[6:0], w_sda};
              r_bitcnt <= r_bitcnt + BIT_CNT_W'(1);
            end else if (w_scl_fall && (r_bitcnt == BITS_PER_BYTE)) begin
              r_bitcnt <= '0;
              if (r_state == ST_ADDR) begin
                if (r_shift[7:1] == ADDRESS) begin
                  r_state <= ST_ADDR_ACK;
                  r_rw    <= r_shift[0];
                  r_oe    <= 1'b1;
                  r_busy  <= 1'b1;
                end else begin
                  r_state <= ST_WAIT_STOP;
                  r_oe    <= 1'b0;
                  r_busy  <= 1'b0;
                end
              end else if (r_state == ST_REG) begin
                r_ptr   <= r_shift;
                r_state <= ST_REG_ACK;
                r_oe    <= 1'b1;
              end else begin
                r_wdata <= r_shift;
                r_state <= ST_WDATA_ACK;
                r_oe    <= 1'b1;
              end
            end
          end

          ST_ADDR_ACK: begin
            if (w_scl_fall) begin
              r_oe <= 1'b0;
              if (r_rw == RW_READ) begin
                r_state <= ST_RDATA;
                r_re    <= 1'b1;
              end else begin
                r_state <= ST_REG;
              end
            end
          end

          ST_REG_ACK: begin
            if (w_scl_fall) begin
              r_oe    <= 1'b0;
              r_state <= ST_WDATA;
            end
          end

          ST_WDATA_ACK: begin
            if (w_scl_fall) begin
              r_oe    <= 1'b0;
              r_we    <= 1'b1;
              r_state <= ST_WDATA;
            end
          end

          ST_RDATA: begin
            if (w_scl_rise) begin
              r_bitcnt <= r_bitcnt + BIT_CNT_W'(1);
            end else if (w_scl_fall && (r_bitcnt != '0)) begin
              if (r_bitcnt == BITS_PER_BYTE) begin
                r_bitcnt <= '0;
                r_oe     <= 1'b0;
                r_state  <= ST_RDATA_ACK;
              end else begin
                r_tx <= {r_tx[6:0], 1'b0};
                r_oe <= ~r_tx[6];
              end
            end
          end

          ST_RDATA_ACK: begin
            if (w_scl_rise) begin
              r_ack <= w_sda;
            end else if (w_scl_fall) begin
              if (r_ack == ACK) begin
                r_ptr   <= r_ptr + 8'd1;
                r_re    <= 1'b1;
                r_state <= ST_RDATA;
              end else begin
                r_oe    <= 1'b0;
                r_busy  <= 1'b0;
                r_state <= ST_WAIT_STOP;
              end
            end
          end

          default: begin
            // IDLE and WAIT_STOP ignore bits; only START/STOP move them
          end
        endcase
      end
    end
  end

  assign sda_oe_o    = r_oe;
  assign reg_addr_o  = r_ptr;
  assign reg_wdata_o = r_wdata;
  assign reg_we_o    = r_we;
  assign reg_re_o    = r_re;
  assign busy_o      = r_busy;

endmodule
